// File: rtl/tmr_vote_monitor.sv
// Majority vote point for a triplicated register bus, with per-lane SEU
// bookkeeping: sticky fault flags, a saturating error count, persistent-fault detect.

module tmr_lane_persist #(
    parameter int PERSIST = 4
) (
    input  logic c,
    input  logic rst,
    input  logic clr,
    input  logic valid,
    input  logic fault,
    output logic err_flag,
    output logic dead
);
    typedef enum logic [1:0] {ST_OK, ST_SUSPECT, ST_DEAD} state_t;

    localparam logic [3:0] PMAX = 4'(PERSIST);

    state_t     state;
    logic [3:0] pc;
    logic [3:0] pc_base, pc_nxt;
    logic       dead_base, flag_base, dead_nxt;

    // clr wipes history first, then this cycle's observation is folded in
    always_comb begin
        pc_base   = clr ? 4'd0 : pc;
        dead_base = !clr && (state == ST_DEAD);
        flag_base = !clr && err_flag;
        pc_nxt    = pc_base;
        if (valid)
            pc_nxt = fault ? ((pc_base >= PMAX) ? PMAX : pc_base + 4'd1) : 4'd0;
        dead_nxt  = dead_base || (pc_nxt == PMAX);
    end

    always_ff @(posedge c) begin
        if (rst) begin
            state    <= ST_OK;
            pc       <= 4'd0;
            dead     <= 1'b0;
            err_flag <= 1'b0;
        end else begin
            pc       <= pc_nxt;
            dead     <= dead_nxt;
            err_flag <= flag_base || (valid && fault);
            if (dead_nxt)
                state <= ST_DEAD;
            else if (pc_nxt != 4'd0)
                state <= ST_SUSPECT;
            else
                state <= ST_OK;
        end
    end
endmodule

module tmr_vote_monitor #(
    parameter int W       = 8,
    parameter int CW      = 8,
    parameter int PERSIST = 4
) (
    input  logic          c,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [W-1:0]  dA,
    input  logic [W-1:0]  dB,
    input  logic [W-1:0]  dC,
    input  logic          clr,
    output logic [W-1:0]  q,
    output logic          q_valid,
    output logic          tmr_error,
    output logic          multi_fault,
    output logic [2:0]    err_lane,
    output logic [2:0]    lane_dead,
    output logic [CW-1:0] err_cnt
);
    localparam logic [CW-1:0] CMAX = '1;

    logic [2:0][W-1:0] rep;
    logic [W-1:0]      v;
    logic [2:0]        f;
    logic              any_f, multi_f;
    logic [CW-1:0]     cnt_base;

    assign rep     = {dC, dB, dA};
    assign v       = (dA & dB) | (dA & dC) | (dB & dC);
    assign any_f   = |f;
    assign multi_f = (f[0] & f[1]) | (f[0] & f[2]) | (f[1] & f[2]);

    genvar k;
    generate
        for (k = 0; k < 3; k++) begin : g_lane
            assign f[k] = in_valid && (|(rep[k] ^ v));

            tmr_lane_persist #(.PERSIST(PERSIST)) u_lane (
                .c        (c),
                .rst      (rst),
                .clr      (clr),
                .valid    (in_valid),
                .fault    (f[k]),
                .err_flag (err_lane[k]),
                .dead     (lane_dead[k])
            );
        end
    endgenerate

    assign cnt_base = clr ? '0 : err_cnt;

    always_ff @(posedge c) begin
        if (rst) begin
            q           <= '0;
            q_valid     <= 1'b0;
            tmr_error   <= 1'b0;
            multi_fault <= 1'b0;
            err_cnt     <= '0;
        end else begin
            q_valid     <= in_valid;
            tmr_error   <= any_f;
            multi_fault <= multi_f;
            if (in_valid)
                q <= v;
            // saturate rather than wrap so a status read never under-reports
            if (any_f && cnt_base != CMAX)
                err_cnt <= cnt_base + 1'b1;
            else
                err_cnt <= cnt_base;
        end
    end
endmodule

// File: tb/tb_tmr_vote_monitor.sv
// Directed bench for tmr_vote_monitor (W=8, CW=2, PERSIST=4).

module tb_tmr_vote_monitor;
    logic       c = 1'b0;
    logic       rst, in_valid, clr;
    logic [7:0] dA, dB, dC;
    logic [7:0] q;
    logic       q_valid, tmr_error, multi_fault;
    logic [2:0] err_lane, lane_dead;
    logic [1:0] err_cnt;

    int tests = 0;
    int fails = 0;

    always #5 c = ~c;

    tmr_vote_monitor #(.W(8), .CW(2), .PERSIST(4)) dut (
        .c(c), .rst(rst), .in_valid(in_valid), .dA(dA), .dB(dB), .dC(dC), .clr(clr),
        .q(q), .q_valid(q_valid), .tmr_error(tmr_error), .multi_fault(multi_fault),
        .err_lane(err_lane), .lane_dead(lane_dead), .err_cnt(err_cnt)
    );

    task automatic step(input logic vld, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] cc, input logic cl);
        in_valid = vld; dA = a; dB = b; dC = cc; clr = cl;
        @(posedge c);
        #1;
        in_valid = 1'b0; clr = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(1'b1, 8'hFF, 8'hFF, 8'h0F, 1'b1);
            tests++;
            if (q !== 8'h00 || q_valid !== 1'b0 || tmr_error !== 1'b0 || multi_fault !== 1'b0 ||
                err_cnt !== 2'd0 || err_lane !== 3'b000 || lane_dead !== 3'b000) begin
                fails++;
                $display("FAIL reset[%0d]: q=%h qv=%b te=%b mf=%b cnt=%0d el=%b ld=%b, want all 0",
                         i, q, q_valid, tmr_error, multi_fault, err_cnt, err_lane, lane_dead);
            end
        end
        rst = 1'b0;
    endtask

    task automatic test_clean;
        step(1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0);
        tests++;
        if (q !== 8'h5A || q_valid !== 1'b1 || tmr_error !== 1'b0 || multi_fault !== 1'b0 || err_cnt !== 2'd0) begin
            fails++;
            $display("FAIL clean: q=%h qv=%b te=%b mf=%b cnt=%0d, want 5a 1 0 0 0",
                     q, q_valid, tmr_error, multi_fault, err_cnt);
        end
    endtask

    task automatic test_single_fault;
        logic [1:0] exp_cnt;
        step(1'b1, 8'h5B, 8'h5A, 8'h5A, 1'b0);
        tests++;
        if (q !== 8'h5A || tmr_error !== 1'b1 || multi_fault !== 1'b0 || err_lane !== 3'b001 || err_cnt !== 2'd1) begin
            fails++;
            $display("FAIL single: q=%h te=%b mf=%b el=%b cnt=%0d, want 5a 1 0 001 1",
                     q, tmr_error, multi_fault, err_lane, err_cnt);
        end
        step(1'b1, 8'h5A, 8'h5A, 8'h5A, 1'b0);
        tests++;
        if (err_lane !== 3'b001 || tmr_error !== 1'b0 || err_cnt !== 2'd1 || lane_dead !== 3'b000) begin
            fails++;
            $display("FAIL single_clean: el=%b te=%b cnt=%0d ld=%b, want 001 0 1 000",
                     err_lane, tmr_error, err_cnt, lane_dead);
        end
        // lane A back to OK: three more faults must not reach PERSIST; counter saturates at 3
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h5A, 8'h5A ^ 8'h00, 8'h5A, 1'b0);
            dA = 8'h00;
        end
        tests++;
        if (err_cnt !== 2'd1) begin
            fails++;
            $display("FAIL single_nofault_cnt: cnt=%0d, want 1", err_cnt);
        end
        exp_cnt = 2'd1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hDA, 8'h5A, 8'h5A, 1'b0);
            exp_cnt = (exp_cnt == 2'd3) ? 2'd3 : exp_cnt + 2'd1;
            tests++;
            if (lane_dead !== 3'b000 || err_cnt !== exp_cnt) begin
                fails++;
                $display("FAIL single_refault[%0d]: ld=%b cnt=%0d, want 000 %0d", i, lane_dead, err_cnt, exp_cnt);
            end
        end
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        tests++;
        if (err_cnt !== 2'd0 || err_lane !== 3'b000 || lane_dead !== 3'b000 || q !== 8'h5A || q_valid !== 1'b0) begin
            fails++;
            $display("FAIL idle_clr: cnt=%0d el=%b ld=%b q=%h qv=%b, want 0 000 000 5a 0",
                     err_cnt, err_lane, lane_dead, q, q_valid);
        end
    endtask

    task automatic test_multi_fault;
        step(1'b1, 8'h01, 8'h02, 8'h00, 1'b0);
        tests++;
        if (q !== 8'h00 || tmr_error !== 1'b1 || multi_fault !== 1'b1 || err_lane !== 3'b011 || err_cnt !== 2'd1) begin
            fails++;
            $display("FAIL multi: q=%h te=%b mf=%b el=%b cnt=%0d, want 00 1 1 011 1",
                     q, tmr_error, multi_fault, err_lane, err_cnt);
        end
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        tests++;
        if (multi_fault !== 1'b0 || tmr_error !== 1'b0 || err_cnt !== 2'd0 || err_lane !== 3'b000) begin
            fails++;
            $display("FAIL multi_pulse: mf=%b te=%b cnt=%0d el=%b, want 0 0 0 000", multi_fault, tmr_error, err_cnt, err_lane);
        end
    endtask

    task automatic test_persist;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'h33, 8'h32, 8'h33, 1'b0);
            tests++;
            if (lane_dead !== 3'b000 || q !== 8'h33) begin
                fails++;
                $display("FAIL persist_pre[%0d]: ld=%b q=%h, want 000 33", i, lane_dead, q);
            end
        end
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 8'hFF, 8'h00, 8'h00, 1'b0);
            tests++;
            if (lane_dead !== 3'b000 || q_valid !== 1'b0 || tmr_error !== 1'b0 || q !== 8'h33) begin
                fails++;
                $display("FAIL persist_gap[%0d]: ld=%b qv=%b te=%b q=%h, want 000 0 0 33",
                         i, lane_dead, q_valid, tmr_error, q);
            end
        end
        step(1'b1, 8'h33, 8'h32, 8'h33, 1'b0);
        tests++;
        if (lane_dead !== 3'b010 || err_lane !== 3'b010 || err_cnt !== 2'd3) begin
            fails++;
            $display("FAIL persist_dead: ld=%b el=%b cnt=%0d, want 010 010 3", lane_dead, err_lane, err_cnt);
        end
        step(1'b1, 8'h33, 8'h33, 8'h33, 1'b0);
        tests++;
        if (lane_dead !== 3'b010 || tmr_error !== 1'b0) begin
            fails++;
            $display("FAIL persist_sticky: ld=%b te=%b, want 010 0", lane_dead, tmr_error);
        end
        step(1'b0, 8'h00, 8'h00, 8'h00, 1'b1);
        tests++;
        if (lane_dead !== 3'b000 || err_lane !== 3'b000 || err_cnt !== 2'd0) begin
            fails++;
            $display("FAIL persist_clr: ld=%b el=%b cnt=%0d, want 000 000 0", lane_dead, err_lane, err_cnt);
        end
    endtask

    task automatic test_saturate_clr;
        logic [1:0] exp_cnt;
        logic [2:0] exp_dead;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 8'h0F, 8'h00, 8'h00, 1'b0);
            exp_cnt  = (i >= 2) ? 2'd3 : 2'(i + 1);
            exp_dead = (i >= 3) ? 3'b001 : 3'b000;
            tests++;
            if (err_cnt !== exp_cnt || lane_dead !== exp_dead) begin
                fails++;
                $display("FAIL sat[%0d]: cnt=%0d ld=%b, want %0d %b", i, err_cnt, lane_dead, exp_cnt, exp_dead);
            end
        end
        step(1'b1, 8'hAA, 8'hAA, 8'hAB, 1'b1);
        tests++;
        if (err_cnt !== 2'd1 || err_lane !== 3'b100 || lane_dead !== 3'b000 ||
            q !== 8'hAA || q_valid !== 1'b1 || tmr_error !== 1'b1) begin
            fails++;
            $display("FAIL clr_fault: cnt=%0d el=%b ld=%b q=%h qv=%b te=%b, want 1 100 000 aa 1 1",
                     err_cnt, err_lane, lane_dead, q, q_valid, tmr_error);
        end
        // clr left lane C at pc=1: dead after exactly three more faults
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hAA, 8'hAA, 8'hAB, 1'b0);
            exp_dead = (i == 2) ? 3'b100 : 3'b000;
            tests++;
            if (lane_dead !== exp_dead) begin
                fails++;
                $display("FAIL clr_pc[%0d]: ld=%b, want %b", i, lane_dead, exp_dead);
            end
        end
    endtask

    task automatic test_rst_over_clr;
        rst = 1'b1;
        step(1'b1, 8'h01, 8'h02, 8'h04, 1'b1);
        rst = 1'b0;
        tests++;
        if (q !== 8'h00 || q_valid !== 1'b0 || tmr_error !== 1'b0 || multi_fault !== 1'b0 ||
            err_cnt !== 2'd0 || err_lane !== 3'b000 || lane_dead !== 3'b000) begin
            fails++;
            $display("FAIL rst_priority: q=%h qv=%b te=%b mf=%b cnt=%0d el=%b ld=%b, want all 0",
                     q, q_valid, tmr_error, multi_fault, err_cnt, err_lane, lane_dead);
        end
    endtask

    initial begin
        rst = 1'b0; in_valid = 1'b0; clr = 1'b0; dA = '0; dB = '0; dC = '0;
        @(posedge c);
        #1;
        test_reset;
        test_clean;
        test_single_fault;
        test_multi_fault;
        test_persist;
        test_saturate_clr;
        test_rst_over_clr;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
